prog_mem: RTL and testbench
===========================

Name: prog_mem

Overview:
- Instruction memory that feeds the CPU fetch path.
- 16 words x 8 bits: opcode in [7:4], immediate in [3:0].
- Read port: the CPU's program-counter address in, the instruction word out to the decoder.
- Includes a byte-serial load engine so a host or test harness can replace the program at run time.
- Holds the CPU (cpu_hold) while a load is in progress.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W words.
- DATA_W, 8, instruction word width.
- INIT_PROG, 128'h0, reset image. Word i = INIT_PROG[i*DATA_W +: DATA_W].

Ports:
- clk  input  1  system clock (single clock domain).
- rst  input  1  reset, synchronous, active-high.
- addr  input  ADDR_W  fetch address from CPU instruction pointer.
- data  output  DATA_W  instruction word to the CPU decoder.
- load_start  input  1  request to begin a full-image load.
- load_abort  input  1  abandon the load in progress.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  DATA_W  next program byte, word 0 first.
- load_ready  output  1  block accepts a byte this cycle.
- load_done  output  1  one-cycle pulse: a full image was written.
- load_count  output  ADDR_W+1  number of words written in the current load.
- cpu_hold  output  1  CPU must not advance state while high.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - Array reloaded from INIT_PROG.
  - State = IDLE; write pointer = 0.
  - load_ready=0, load_done=0, load_count=0, cpu_hold=0.
- Read path:
  - Combinational: data = mem[addr]. Zero latency, so the CPU samples it in the same cycle.
  - While state != IDLE, data is forced to 8'h00 (ADD A,0, a no-op).
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start. Pointer cleared to 0; load_count cleared to 0.
  - LOAD:
    - load_ready=1.
    - Each cycle with load_valid&load_ready: mem[ptr] <= load_data, ptr++, load_count++.
    - When the write of word 15 occurs (count becomes 16): LOAD -> DONE.
    - load_abort in LOAD -> IDLE. Words already written are kept; unwritten words keep old contents. load_count holds its value; no load_done.
    - If load_abort and a valid byte coincide, abort wins: the byte is not written.
    - load_start while in LOAD is ignored.
  - DONE: load_done=1 for exactly one cycle, load_ready=0, then -> IDLE unconditionally.
- cpu_hold = 1 in LOAD and DONE, 0 in IDLE. It is registered by the state, so it asserts the cycle after load_start is sampled.
- load_valid while load_ready=0 is ignored: no write, no backpressure error.
- Pointer is ADDR_W bits and never wraps within a load, because the transition to DONE happens at count 16. load_count saturates at 16.
- rst mid-load: immediate return to reset state. Array is restored to INIT_PROG and partial loads are discarded.
- Simultaneous load_start and rst: rst wins.
- Array writes occur only in LOAD. The CPU never writes memory.

Decomposition:
- Add to the shared CPU package (lib_cpu):
  - typedef enum MEM_STATE {IDLE, LOAD, DONE}.
  - Constants PROG_DEPTH=16 and NOP_WORD=8'h00.
- One sub-module is natural: prog_loader.
  - Contains the FSM, pointer, and count; drives write-enable, write-address, load_ready, load_done, and cpu_hold.
  - prog_mem keeps the array, the reset image, and the read mux.

Test Plan:
1. Reset with INIT_PROG word3=8'hB5: after rst, addr=3 -> data=8'hB5; cpu_hold=0; load_ready=0.
2. Full load:
   - Pulse load_start, then stream bytes 8'h10..8'h1F with load_valid held high.
   - Expect load_ready high for 16 cycles and load_done a single pulse after the 16th byte.
   - Then addr=4 -> data=8'h14; cpu_hold low again.
3. Gapped valid: same load with load_valid toggled every other cycle -> identical final contents; load_count steps only on accepted bytes.
4. Abort:
   - Load 5 bytes 8'hAA, then assert load_abort together with a 6th byte 8'hCC.
   - Expect state IDLE, load_count=5, no load_done.
   - Words 0-4 = 8'hAA; word 5 unchanged from the previous image.
5. Read during load: with addr=2, data=8'h00 throughout LOAD/DONE and returns to the new mem[2] in IDLE.
6. Reset mid-load: assert rst after 8 bytes -> array equals INIT_PROG, load_count=0, cpu_hold=0; a load_start on the same cycle as rst is ignored.

Source files
------------

// File: rtl/lib_cpu_pkg.sv
// Shared CPU definitions: program-memory load states and instruction-memory constants.
package lib_cpu;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} MEM_STATE;

  localparam int         PROG_DEPTH = 16;
  localparam logic [7:0] NOP_WORD   = 8'h00;
endpackage

// File: rtl/prog_loader.sv
// Byte-serial program load sequencer: FSM, write pointer and word count.
// Write-enable is combinational from state and inputs; ready/done/hold come straight from state.
module prog_loader
  import lib_cpu::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic              i_load_abort,
  input  logic              i_load_valid,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_cpu_hold
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'((2 ** ADDR_W) - 1);

  MEM_STATE          r_state;
  MEM_STATE          w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      LOAD: begin
        // Abort takes priority over a coincident byte, which is dropped.
        if (i_load_abort) begin
          w_state_nxt = IDLE;
        end else if (i_load_valid) begin
          w_we        = 1'b1;
          w_ptr_nxt   = r_ptr + ADDR_W'(1);
          w_count_nxt = r_count + CNT_W'(1);
          if (r_ptr == LAST_PTR) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_we         = w_we;
  assign o_waddr      = r_ptr;
  assign o_load_ready = (r_state == LOAD);
  assign o_load_done  = (r_state == DONE);
  assign o_load_count = r_count;
  assign o_cpu_hold   = (r_state != IDLE);
endmodule

// File: rtl/prog_mem.sv
// Instruction memory with zero-latency fetch read and a byte-serial run-time loader.
// Fetch returns a no-op while a load holds the CPU.
module prog_mem
  import lib_cpu::*;
#(
  parameter int ADDR_W = $clog2(PROG_DEPTH),
  parameter int DATA_W = 8,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT_PROG = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_load_start,
  input  logic              i_load_abort,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_cpu_hold
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_hold;

  prog_loader #(.ADDR_W(ADDR_W)) u_loader (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load_start (i_load_start),
    .i_load_abort (i_load_abort),
    .i_load_valid (i_load_valid),
    .o_we         (w_we),
    .o_waddr      (w_waddr),
    .o_load_ready (o_load_ready),
    .o_load_done  (o_load_done),
    .o_load_count (o_load_count),
    .o_cpu_hold   (w_hold)
  );

  // Reset restores the boot image, discarding any partial load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT_PROG[i*DATA_W +: DATA_W];
      end
    end else if (w_we) begin
      r_mem[w_waddr] <= i_load_data;
    end
  end

  assign o_data     = w_hold ? DATA_W'(NOP_WORD) : r_mem[i_addr];
  assign o_cpu_hold = w_hold;
endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: reset image, full/gapped/aborted loads, fetch masking, reset mid-load.
module tb_prog_mem;
  localparam logic [127:0] INIT = 128'h8F8E8D8C_8B8A8988_87868584_B5828180;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] data;
  logic       load_start, load_abort, load_valid;
  logic [7:0] load_data;
  logic       load_ready, load_done, cpu_hold;
  logic [4:0] load_count;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] m_mem [16];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t rst_tbl [5];

  prog_mem #(.ADDR_W(4), .DATA_W(8), .INIT_PROG(INIT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_addr       (addr),
    .o_data       (data),
    .i_load_start (load_start),
    .i_load_abort (load_abort),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .o_load_done  (load_done),
    .o_load_count (load_count),
    .o_cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    logic [127:0] img;
    img = INIT;
    for (int i = 0; i < 16; i++) m_mem[i] = img[i*8 +: 8];
  endtask

  // Scoreboarded sweep of all 16 words against the model.
  task automatic check_image(input string name);
    logic [7:0] e;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      exp_q.push_back(m_mem[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk(name, {24'h0, data}, {24'h0, e});
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    chk("hold_low_on_start_cycle", {31'h0, cpu_hold}, 32'h0);
    step();
    load_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; load_start = 0; load_abort = 0; load_valid = 0; load_data = '0;
    model_init();
    rst_tbl[0] = '{4'd3,  8'hB5};
    rst_tbl[1] = '{4'd0,  8'h80};
    rst_tbl[2] = '{4'd2,  8'h82};
    rst_tbl[3] = '{4'd4,  8'h84};
    rst_tbl[4] = '{4'd15, 8'h8F};
    step(); step();
    rst = 1'b0;

    // 1: reset state
    @(negedge clk);
    chk("rst_hold", {31'h0, cpu_hold}, 32'h0);
    chk("rst_ready", {31'h0, load_ready}, 32'h0);
    chk("rst_done", {31'h0, load_done}, 32'h0);
    chk("rst_count", {27'h0, load_count}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      addr = rst_tbl[i].addr;
      @(negedge clk);
      chk("rst_word", {24'h0, data}, {24'h0, rst_tbl[i].exp});
    end

    // 2 + 5: full back-to-back load, fetch of word 2 masked throughout
    step();
    addr = 4'd2;
    start_load();
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h10 + 8'(i);
      m_mem[i]   = load_data;
      @(negedge clk);
      chk("full_ready", {31'h0, load_ready}, 32'h1);
      chk("full_nop", {24'h0, data}, 32'h0);
      chk("full_done_early", {31'h0, load_done}, 32'h0);
      step();
    end
    load_valid = 1'b0;
    @(negedge clk);
    chk("full_done", {31'h0, load_done}, 32'h1);
    chk("full_done_ready", {31'h0, load_ready}, 32'h0);
    chk("full_done_hold", {31'h0, cpu_hold}, 32'h1);
    chk("full_done_nop", {24'h0, data}, 32'h0);
    chk("full_count", {27'h0, load_count}, 32'd16);
    step();
    @(negedge clk);
    chk("full_done_pulse", {31'h0, load_done}, 32'h0);
    chk("full_hold_clear", {31'h0, cpu_hold}, 32'h0);
    chk("full_word2", {24'h0, data}, 32'h12);
    addr = 4'd4;
    @(negedge clk);
    chk("full_word4", {24'h0, data}, 32'h14);
    check_image("full_image");

    // 3: gapped valid, with a stray load_start mid-load
    step();
    start_load();
    for (int j = 0; j < 16; j++) begin
      load_valid = 1'b1;
      load_data  = 8'h10 + 8'(j);
      @(negedge clk);
      chk("gap_count_pre", {27'h0, load_count}, 32'(j));
      step();
      load_valid = 1'b0;
      if (j < 15) begin
        load_start = (j == 7);
        @(negedge clk);
        chk("gap_count_idle", {27'h0, load_count}, 32'(j + 1));
        chk("gap_ready", {31'h0, load_ready}, 32'h1);
        step();
        load_start = 1'b0;
      end
    end
    @(negedge clk);
    chk("gap_done", {31'h0, load_done}, 32'h1);
    chk("gap_count", {27'h0, load_count}, 32'd16);
    step();
    check_image("gap_image");

    // 4: abort after 5 bytes; coincident byte is dropped
    step();
    start_load();
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hAA;
      m_mem[i]   = 8'hAA;
      step();
    end
    load_data  = 8'hCC;
    load_abort = 1'b1;
    step();
    load_abort = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk("abort_hold", {31'h0, cpu_hold}, 32'h0);
    chk("abort_count", {27'h0, load_count}, 32'd5);
    chk("abort_done", {31'h0, load_done}, 32'h0);
    chk("abort_ready", {31'h0, load_ready}, 32'h0);
    // valid in IDLE must not write
    load_valid = 1'b1;
    load_data  = 8'hEE;
    step();
    load_valid = 1'b0;
    check_image("abort_image");

    // 6: reset mid-load with a coincident load_start
    step();
    start_load();
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h55;
      step();
    end
    load_valid = 1'b0;
    @(negedge clk);
    chk("mid_count", {27'h0, load_count}, 32'd8);
    rst = 1'b1;
    load_start = 1'b1;
    step();
    rst = 1'b0;
    load_start = 1'b0;
    model_init();
    @(negedge clk);
    chk("rstmid_hold", {31'h0, cpu_hold}, 32'h0);
    chk("rstmid_count", {27'h0, load_count}, 32'h0);
    chk("rstmid_ready", {31'h0, load_ready}, 32'h0);
    check_image("rstmid_image");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
